// File: rtl/fb_pkg.sv
// Shared constants, types and FSM encoding for the ping-pong frame store controller.
package fb_pkg;

    localparam logic [9:0]  H_ACTIVE  = 10'd640;
    localparam logic [9:0]  V_ACTIVE  = 10'd480;
    localparam logic [18:0] FB_PIXELS = 19'd307200;
    localparam int          ADDR_W    = 19;
    localparam int          DATA_W    = 8;
    localparam logic [2:0]  SETTLE    = 3'd4;

    typedef logic [7:0]  pixel_t;
    typedef logic [18:0] fb_addr_t;

    typedef enum logic [1:0] {
        RENDER,
        WAIT_VBLANK,
        SWAP
    } swap_state_t;

endpackage

// File: rtl/fb_scan_addr.sv
// Scan-side read address generation plus the visible/front-select delay line
// that travels alongside the one-cycle frame RAM read.
module fb_scan_addr
    import fb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [9:0]        i_hc,
    input  logic [9:0]        i_vc,
    input  logic              i_front_sel,
    output logic [ADDR_W-1:0] o_raddr,
    output logic              o_vis_d2,
    output logic              o_sel_d2
);

    logic     w_visible;
    fb_addr_t w_lin_addr;

    fb_addr_t r_raddr;
    logic     r_vis_d1;
    logic     r_vis_d2;
    logic     r_sel_d1;
    logic     r_sel_d2;

    assign w_visible  = (i_hc < H_ACTIVE) && (i_vc < V_ACTIVE);
    // vc*640 built as vc*512 + vc*128 so no multiplier is inferred
    assign w_lin_addr = ({9'd0, i_vc} << 9) + ({9'd0, i_vc} << 7) + {9'd0, i_hc};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_raddr  <= '0;
            r_vis_d1 <= 1'b0;
            r_vis_d2 <= 1'b0;
            r_sel_d1 <= 1'b0;
            r_sel_d2 <= 1'b0;
        end else begin
            r_raddr  <= w_visible ? w_lin_addr : '0;
            r_vis_d1 <= w_visible;
            r_vis_d2 <= r_vis_d1;
            r_sel_d1 <= i_front_sel;
            r_sel_d2 <= r_sel_d1;
        end
    end

    assign o_raddr  = r_raddr;
    assign o_vis_d2 = r_vis_d2;
    assign o_sel_d2 = r_sel_d2;

endmodule

// File: rtl/fb_swap_ctrl.sv
// Ping-pong frame store controller: scan reads the front buffer, the writer fills
// the back buffer, and the two are exchanged only inside a settled vertical blank.
//   state       | meaning
//   RENDER      | writer owns the back buffer, waiting for frame_done
//   WAIT_VBLANK | frame complete, writes blocked until blanking has settled
//   SWAP        | one cycle: front_sel toggled, swap_ack pulsed
module fb_swap_ctrl
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        hc_in,
    input  logic [9:0]        vc_in,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              frame_done,
    output logic              swap_ack,
    output logic              front_sel,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram0_rdata,
    input  logic [DATA_W-1:0] ram1_rdata,
    output logic              ram0_we,
    output logic              ram1_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_active
);

    swap_state_t r_state;
    logic [2:0]  r_settle;
    logic        r_front_sel;
    logic        r_swap_ack;
    logic        r_ram0_we;
    logic        r_ram1_we;
    fb_addr_t    r_ram_waddr;
    pixel_t      r_ram_wdata;
    pixel_t      r_pix_data;
    logic        r_pix_active;

    logic w_vblank;
    logic w_settled;
    logic w_wr_ready;
    logic w_wr_fire;
    logic w_in_range;
    logic w_vis_d2;
    logic w_sel_d2;

    fb_scan_addr u_scan (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_hc        (hc_in),
        .i_vc        (vc_in),
        .i_front_sel (r_front_sel),
        .o_raddr     (ram_raddr),
        .o_vis_d2    (w_vis_d2),
        .o_sel_d2    (w_sel_d2)
    );

    assign w_vblank   = (vc_in >= V_ACTIVE);
    assign w_settled  = (r_settle == SETTLE);
    assign w_wr_ready = (r_state == RENDER);
    assign w_wr_fire  = wr_valid && w_wr_ready;
    assign w_in_range = (wr_addr < FB_PIXELS);

    // Settling for SETTLE blank cycles flushes visible pixels out of the read pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle <= '0;
        end else if (!w_vblank) begin
            r_settle <= '0;
        end else if (!w_settled) begin
            r_settle <= r_settle + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RENDER;
            r_front_sel <= 1'b0;
            r_swap_ack  <= 1'b0;
            r_ram0_we   <= 1'b0;
            r_ram1_we   <= 1'b0;
            r_ram_waddr <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_ram0_we  <= 1'b0;
            r_ram1_we  <= 1'b0;
            r_swap_ack <= 1'b0;
            case (r_state)
                RENDER: begin
                    if (w_wr_fire && w_in_range) begin
                        r_ram_waddr <= wr_addr;
                        r_ram_wdata <= wr_data;
                        r_ram0_we   <= r_front_sel;
                        r_ram1_we   <= ~r_front_sel;
                    end
                    if (frame_done) begin
                        r_state <= WAIT_VBLANK;
                    end
                end
                WAIT_VBLANK: begin
                    if (w_settled) begin
                        r_state     <= SWAP;
                        r_front_sel <= ~r_front_sel;
                        r_swap_ack  <= 1'b1;
                    end
                end
                SWAP: begin
                    r_state <= RENDER;
                end
                default: begin
                    r_state <= RENDER;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_data   <= '0;
            r_pix_active <= 1'b0;
        end else begin
            r_pix_data   <= w_vis_d2 ? (w_sel_d2 ? ram1_rdata : ram0_rdata) : '0;
            r_pix_active <= w_vis_d2;
        end
    end

    assign wr_ready   = w_wr_ready;
    assign swap_ack   = r_swap_ack;
    assign front_sel  = r_front_sel;
    assign ram0_we    = r_ram0_we;
    assign ram1_we    = r_ram1_we;
    assign ram_waddr  = r_ram_waddr;
    assign ram_wdata  = r_ram_wdata;
    assign pix_data   = r_pix_data;
    assign pix_active = r_pix_active;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Scoreboard bench for fb_swap_ctrl: stimulus queues expectations with a due cycle,
// a negedge monitor compares DUT outputs when each expectation falls due.
module tb_fb_swap_ctrl;

    localparam int K_PIX = 0;
    localparam int K_WE  = 1;
    localparam int K_CTL = 2;

    typedef struct {
        int          kind;
        int          due;
        string       tag;
        logic [7:0]  d;
        logic        a;
        logic        we0;
        logic        we1;
        logic [18:0] addr;
        logic        ack;
        logic        sel;
        logic        rdy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  hc_in;
    logic [9:0]  vc_in;
    logic        wr_valid;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        frame_done;
    logic        swap_ack;
    logic        front_sel;
    logic [18:0] ram_raddr;
    logic [7:0]  ram0_rdata;
    logic [7:0]  ram1_rdata;
    logic        ram0_we;
    logic        ram1_we;
    logic [18:0] ram_waddr;
    logic [7:0]  ram_wdata;
    logic [7:0]  pix_data;
    logic        pix_active;

    logic [7:0] mem0 [0:307199];
    logic [7:0] mem1 [0:307199];

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_ack = 0;
    int   n_ack_exp = 0;
    logic exp_sel = 1'b0;
    int   mi;
    int   c0;

    fb_swap_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .hc_in      (hc_in),
        .vc_in      (vc_in),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .frame_done (frame_done),
        .swap_ack   (swap_ack),
        .front_sel  (front_sel),
        .ram_raddr  (ram_raddr),
        .ram0_rdata (ram0_rdata),
        .ram1_rdata (ram1_rdata),
        .ram0_we    (ram0_we),
        .ram1_we    (ram1_we),
        .ram_waddr  (ram_waddr),
        .ram_wdata  (ram_wdata),
        .pix_data   (pix_data),
        .pix_active (pix_active)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame RAM models: one-cycle registered read, synchronous write
    always @(posedge clk) begin
        if (ram_raddr < 19'd307200) begin
            ram0_rdata <= mem0[ram_raddr];
            ram1_rdata <= mem1[ram_raddr];
        end
        if (ram0_we && ram_waddr < 19'd307200) mem0[ram_waddr] <= ram_wdata;
        if (ram1_we && ram_waddr < 19'd307200) mem1[ram_waddr] <= ram_wdata;
    end

    function automatic logic [7:0] ref_pix(input int h, input int v, input logic sel);
        int a;
        if (h >= 640 || v >= 480) return 8'h00;
        a = v * 640 + h;
        return sel ? (a[7:0] ^ 8'hA5) : a[7:0];
    endfunction

    task automatic check(input exp_t e);
        n_vec++;
        case (e.kind)
            K_PIX: if (pix_data !== e.d || pix_active !== e.a) begin
                n_bad++;
                $display("FAIL %s: got data=%h active=%b, want data=%h active=%b",
                         e.tag, pix_data, pix_active, e.d, e.a);
            end
            K_WE: if (ram0_we !== e.we0 || ram1_we !== e.we1 ||
                      ((e.we0 || e.we1) && (ram_waddr !== e.addr || ram_wdata !== e.d))) begin
                n_bad++;
                $display("FAIL %s: got we0=%b we1=%b addr=%0d data=%h, want we0=%b we1=%b addr=%0d data=%h",
                         e.tag, ram0_we, ram1_we, ram_waddr, ram_wdata, e.we0, e.we1, e.addr, e.d);
            end
            default: if (swap_ack !== e.ack || front_sel !== e.sel || wr_ready !== e.rdy) begin
                n_bad++;
                $display("FAIL %s: got ack=%b sel=%b ready=%b, want ack=%b sel=%b ready=%b",
                         e.tag, swap_ack, front_sel, wr_ready, e.ack, e.sel, e.rdy);
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (swap_ack === 1'b1) n_ack++;
        mi = 0;
        while (mi < q.size()) begin
            if (q[mi].due <= cyc) begin
                check(q[mi]);
                q.delete(mi);
            end else begin
                mi++;
            end
        end
    end

    task automatic exp_pix(input string tag, input int dly, input logic [7:0] d, input logic a);
        exp_t e;
        e.kind = K_PIX; e.due = cyc + dly; e.tag = tag; e.d = d; e.a = a;
        q.push_back(e);
    endtask

    task automatic exp_we(input string tag, input int dly, input logic w0, input logic w1,
                          input logic [18:0] addr, input logic [7:0] d);
        exp_t e;
        e.kind = K_WE; e.due = cyc + dly; e.tag = tag;
        e.we0 = w0; e.we1 = w1; e.addr = addr; e.d = d;
        q.push_back(e);
    endtask

    task automatic exp_ctl(input string tag, input int dly, input logic ack, input logic sel,
                           input logic rdy);
        exp_t e;
        e.kind = K_CTL; e.due = cyc + dly; e.tag = tag; e.ack = ack; e.sel = sel; e.rdy = rdy;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int h, input int v, input bit pchk);
        hc_in = 10'(h);
        vc_in = 10'(v);
        if (pchk) exp_pix($sformatf("pix h%0d v%0d", h, v), 3, ref_pix(h, v, exp_sel),
                          (h < 640 && v < 480));
        tick();
    endtask

    task automatic write(input logic [18:0] addr, input logic [7:0] d, input bit fd);
        wr_valid = 1'b1; wr_addr = addr; wr_data = d; frame_done = fd;
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0; frame_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hc_in = '0; vc_in = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; frame_done = 1'b0;
        for (int i = 0; i < 307200; i++) begin
            mem0[i] = i[7:0];
            mem1[i] = i[7:0] ^ 8'hA5;
        end
        repeat (3) tick();
        exp_ctl("reset ctl", 0, 1'b0, 1'b0, 1'b1);
        exp_we("reset we", 0, 1'b0, 1'b0, 19'd0, 8'h00);
        exp_pix("reset pix", 0, 8'h00, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // Read pipeline: one full line (hc 0..799 at vc 2) and one full column (vc 0..524 at hc 5)
        for (int h = 0; h < 800; h++) step(h, 2, 1'b1);
        for (int v = 0; v < 525; v++) step(5, v, 1'b1);

        // Writes land in the back buffer (RAM1 while front_sel=0)
        write(19'd100, 8'hE0, 1'b0); step(10, 100, 1'b0); idle_inputs();
        exp_we("wr 100", 0, 1'b0, 1'b1, 19'd100, 8'hE0);
        step(11, 100, 1'b0);
        exp_we("wr 100 one cycle", 0, 1'b0, 1'b0, 19'd0, 8'h00);
        write(19'd307200, 8'h11, 1'b0); step(12, 100, 1'b0); idle_inputs();
        exp_we("wr out of range", 0, 1'b0, 1'b0, 19'd0, 8'h00);
        write(19'd307199, 8'h77, 1'b0); step(13, 100, 1'b0); idle_inputs();
        exp_we("wr last pixel", 0, 1'b0, 1'b1, 19'd307199, 8'h77);

        // frame_done mid-frame, swap after the blank has settled
        frame_done = 1'b1; step(0, 200, 1'b0); idle_inputs();
        exp_ctl("fd ready drop", 0, 1'b0, 1'b0, 1'b0);
        for (int h = 1; h < 4; h++) step(h, 479, 1'b0);
        exp_ctl("still waiting", 0, 1'b0, 1'b0, 1'b0);
        c0 = cyc;
        exp_ctl("pre swap", 4, 1'b0, 1'b0, 1'b0);
        exp_ctl("swap", 5, 1'b1, 1'b1, 1'b0);
        exp_ctl("post swap", 6, 1'b0, 1'b1, 1'b1);
        n_ack_exp++;
        for (int h = 0; h < 10; h++) step(h, 480, 1'b1);
        exp_sel = 1'b1;
        for (int h = 0; h < 16; h++) step(h, 0, 1'b1);

        // Back buffer is now RAM0
        write(19'd200, 8'h3C, 1'b0); step(16, 0, 1'b0); idle_inputs();
        exp_we("wr sel1", 0, 1'b1, 1'b0, 19'd200, 8'h3C);

        // frame_done while already settled: swap one cycle after entering WAIT_VBLANK
        for (int h = 0; h < 6; h++) step(h, 490, 1'b0);
        frame_done = 1'b1; step(6, 490, 1'b0); idle_inputs();
        exp_ctl("settled enter", 0, 1'b0, 1'b1, 1'b0);
        exp_ctl("settled swap", 1, 1'b1, 1'b0, 1'b0);
        exp_ctl("settled post", 2, 1'b0, 1'b0, 1'b1);
        n_ack_exp++;
        for (int h = 7; h < 11; h++) step(h, 490, 1'b0);
        exp_sel = 1'b0;

        // frame_done with a write, a second frame_done, and a blank too short to settle
        write(19'd50, 8'h5A, 1'b1); step(0, 300, 1'b0); idle_inputs();
        exp_we("fd with write", 0, 1'b0, 1'b1, 19'd50, 8'h5A);
        exp_ctl("fd with write ctl", 0, 1'b0, 1'b0, 1'b0);
        write(19'd60, 8'h66, 1'b1); step(1, 300, 1'b0); idle_inputs();
        exp_we("write while waiting", 0, 1'b0, 1'b0, 19'd0, 8'h00);
        for (int h = 0; h < 3; h++) begin
            step(h, 480, 1'b0);
            exp_ctl("short blank", 0, 1'b0, 1'b0, 1'b0);
        end
        for (int h = 0; h < 3; h++) begin
            step(h, 10, 1'b0);
            exp_ctl("blank ended", 0, 1'b0, 1'b0, 1'b0);
        end
        exp_ctl("pre swap 2", 4, 1'b0, 1'b0, 1'b0);
        exp_ctl("swap 2", 5, 1'b1, 1'b1, 1'b0);
        exp_ctl("post swap 2", 6, 1'b0, 1'b1, 1'b1);
        n_ack_exp++;
        for (int h = 0; h < 10; h++) step(h, 480, 1'b0);
        exp_sel = 1'b1;

        // Reset during WAIT_VBLANK discards the pending swap
        frame_done = 1'b1; step(0, 100, 1'b0); idle_inputs();
        step(1, 480, 1'b0);
        step(2, 480, 1'b0);
        rst = 1'b1;
        exp_ctl("rst ctl", 0, 1'b0, 1'b0, 1'b1);
        exp_we("rst we", 0, 1'b0, 1'b0, 19'd0, 8'h00);
        exp_pix("rst pix", 0, 8'h00, 1'b0);
        step(3, 480, 1'b0);
        step(4, 480, 1'b0);
        rst = 1'b0;
        exp_sel = 1'b0;
        for (int h = 5; h < 13; h++) begin
            step(h, 480, 1'b0);
            exp_ctl("after rst", 0, 1'b0, 1'b0, 1'b1);
        end

        repeat (4) tick();
        n_vec++;
        if (n_ack != n_ack_exp) begin
            n_bad++;
            $display("FAIL swap_ack count: got %0d, want %0d", n_ack, n_ack_exp);
        end
        if (q.size() != 0) begin
            n_bad += q.size();
            $display("FAIL scoreboard drain: %0d expectations never checked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
